turbo_mem_reader: RTL and testbench
===================================

TURBO_MEM_READER -- requirements
Module: turbo_mem_reader

Interface
REQ-001 Parameter D_WIDTH, default 13, RAM data word width.
REQ-002 Parameter A_WIDTH, default 16, RAM address width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a burst read; ignored while busy=1.
REQ-006 base_addr  input  A_WIDTH  first RAM address of the burst; sampled with start.
REQ-007 length  input  A_WIDTH  number of words to read; sampled with start; 0 = empty burst.
REQ-008 abort  input  1  synchronous cancel of the current burst.
REQ-009 ram_raddr  output  A_WIDTH  RAM read address, driven to the RAM's synchronous read port.
REQ-010 ram_rdata  input  D_WIDTH  RAM read data, valid exactly one cycle after ram_raddr is presented.
REQ-011 out_data  output  D_WIDTH  streamed word.
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 out_ready  input  1  consumer accepts; a beat transfers on an edge where out_valid=1 and out_ready=1.
REQ-014 out_last  output  1  high with the final beat of a burst.
REQ-015 busy  output  1  burst in progress.
REQ-016 done  output  1  one-cycle pulse on burst completion.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on start with length!=0; RUN->DRAIN when the last read is issued; DRAIN->IDLE on the edge transferring the out_last beat.
REQ-018 start with length=0 in IDLE: stay IDLE, emit no beats, pulse done in the next cycle.
REQ-019 Read issue: in RUN, issue one read per cycle when (fifo_count + inflight - pop) < 2; pop = beat transferring this cycle.
REQ-020 Read address register loads base_addr on start, increments by 1 per issue, wraps modulo 2^A_WIDTH (0xFFFF -> 0x0000).
REQ-021 ram_raddr holds the current address register value in all states.
REQ-022 Remaining-count register loads length on start and decrements by 1 per issue.
REQ-023 Output buffer: 2-entry FIFO; ram_rdata is captured into the FIFO one edge after its issue (inflight flag).
REQ-024 Latency: start sampled at edge E0 -> first read issued in cycle E0..E1 -> data captured at E1+1 -> out_valid=1 from E2 onward.
REQ-025 With out_ready held at 1, sustained throughput is one beat per cycle, no bubbles after the first beat.
REQ-026 out_valid = FIFO not empty; out_data = FIFO head; data order equals address order.
REQ-027 out_last = 1 only on the head beat that is the length-th beat of the burst.
REQ-028 FIFO never overflows; a captured word with a full FIFO is a design error (assertion).
REQ-029 Simultaneous push and pop with one entry: count stays 1, head advances.
REQ-030 busy = 1 in RUN and DRAIN, 0 in IDLE.
REQ-031 done pulses in the cycle after the out_last transfer; never after abort.
REQ-032 abort in RUN or DRAIN: next edge -> IDLE, FIFO cleared, inflight discarded, out_valid=0, no done; abort in IDLE has no effect.
REQ-033 abort and start in the same cycle: abort wins; start ignored.

Reset
REQ-034 n_rst=0 forces: state IDLE, address register 0, remaining 0, FIFO empty, inflight 0.
REQ-035 Output reset values: ram_raddr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.
REQ-036 Reset asserted mid-burst discards the burst; no done after reset release.

Structure
REQ-037 Shared package turbo_mem_pkg holds D_WIDTH=13, A_WIDTH=16 and the FSM state encoding.
REQ-038 One sub-module: turbo_mem_rd_fifo (2-entry, D_WIDTH+1 bits wide including the last flag).
REQ-039 No RAM instance inside; the block connects to an external ram of D_WIDTH x 2^A_WIDTH.

Verification
REQ-040 base=0x0010, length=4, out_ready=1, RAM[a]=a: beats 0x010..0x013 in consecutive cycles, out_last on 0x013, done one cycle later.
REQ-041 base=0xFFFE, length=4: addresses FFFE, FFFF, 0000, 0001 read in order; 4 beats.
REQ-042 length=8, out_ready toggled 1/0 each cycle: all 8 beats in order, no loss or duplication, FIFO count <= 2.
REQ-043 length=0 start: no out_valid, busy stays 0, done pulse next cycle.
REQ-044 length=16, abort after 5 beats: out_valid=0 next cycle, no done; a following start with base=0x0100, length=2 streams 0x100, 0x101 correctly.
REQ-045 n_rst pulsed mid-burst: all outputs at reset values; start after release works normally.

Source files
------------

// File: rtl/turbo_mem_pkg.sv
// Shared constants and FSM encoding for the burst RAM reader.
package turbo_mem_pkg;

    localparam int D_WIDTH = 13;
    localparam int A_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/turbo_mem_rd_fifo.sv
// Two-entry output buffer holding {last flag, data} for the burst reader.
module turbo_mem_rd_fifo
    import turbo_mem_pkg::*;
#(
    parameter int WIDTH = D_WIDTH + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             empty
);

    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  do_pop;

    assign do_pop = pop && (count_q != 2'd0);
    assign head   = mem_q[rd_ptr_q];
    assign count  = count_q;
    assign empty  = (count_q == 2'd0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The issue throttle guarantees a slot is free whenever a read returns.
    assert property (@(posedge clk) disable iff (!n_rst)
        (push && !clear) |-> (count_q != 2'd2));

endmodule

// File: rtl/turbo_mem_reader.sv
// Burst reader: streams length words from a synchronous-read RAM starting at
// base_addr through a 2-entry buffer with a valid/ready output.
module turbo_mem_reader
    import turbo_mem_pkg::*;
#(
    parameter int D_WIDTH = turbo_mem_pkg::D_WIDTH,
    parameter int A_WIDTH = turbo_mem_pkg::A_WIDTH
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] base_addr,
    input  logic [A_WIDTH-1:0] length,
    input  logic               abort,
    output logic [A_WIDTH-1:0] ram_raddr,
    input  logic [D_WIDTH-1:0] ram_rdata,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [A_WIDTH-1:0] remaining_q, remaining_d;
    logic               inflight_q, inflight_d;
    logic               inflight_last_q, inflight_last_d;
    logic               done_q, done_d;

    logic               fifo_clear;
    logic               fifo_push;
    logic               fifo_pop;
    logic [D_WIDTH:0]   fifo_head;
    logic [1:0]         fifo_count;
    logic               fifo_empty;
    logic               room;

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign out_data  = fifo_head[D_WIDTH-1:0];
    assign out_last  = out_valid && fifo_head[D_WIDTH];
    assign fifo_push = inflight_q && !fifo_clear;
    assign ram_raddr = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    // Buffered plus in-flight words, minus the one leaving now, must stay below 2.
    assign room = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, fifo_pop});

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        done_d          = 1'b0;
        fifo_clear      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    addr_d      = base_addr;
                    remaining_d = length;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    fifo_clear = 1'b1;
                end else if (room) begin
                    addr_d          = addr_q + A_WIDTH'(1);
                    remaining_d     = remaining_q - A_WIDTH'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = (remaining_q == A_WIDTH'(1));
                    if (remaining_q == A_WIDTH'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    fifo_clear = 1'b1;
                end else if (fifo_pop && out_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    turbo_mem_rd_fifo #(
        .WIDTH(D_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data ({inflight_last_q, ram_rdata}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_turbo_mem_reader.sv
// Directed bench for turbo_mem_reader: burst vector table plus reset/abort sequences.
module tb_turbo_mem_reader;

    localparam int D_WIDTH = 13;
    localparam int A_WIDTH = 16;

    logic               clk;
    logic               n_rst;
    logic               start;
    logic [A_WIDTH-1:0] base_addr;
    logic [A_WIDTH-1:0] length;
    logic               abort;
    logic [A_WIDTH-1:0] ram_raddr;
    logic [D_WIDTH-1:0] ram_rdata;
    logic [D_WIDTH-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;
    logic               done;

    typedef struct {
        logic [15:0] base;
        logic [15:0] len;
        int          mode;
        int          abort_after;
        int          exp_beats;
        logic [12:0] exp_first;
        bit          exp_last;
        int          exp_done;
        bit          exp_busy;
        logic [15:0] exp_raddr;
    } vec_t;

    vec_t        vecs[8];
    int          total;
    int          bad;
    logic [12:0] got_data[32];
    bit          got_last[32];
    int          got_cycle[32];
    int          beats;
    int          done_cnt;
    int          done_cycle;
    bit          saw_busy;
    bit          saw_valid;

    turbo_mem_reader #(
        .D_WIDTH(D_WIDTH),
        .A_WIDTH(A_WIDTH)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: RAM[a] = a (low data bits), one-cycle synchronous read.
    always @(posedge clk) ram_rdata <= ram_raddr[12:0];

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        int  idle;
        bit  aborted;
        bit  abort_now;
        bit  finished;
        beats      = 0;
        done_cnt   = 0;
        done_cycle = -1;
        saw_busy   = 0;
        saw_valid  = 0;
        aborted    = 0;
        idle       = 0;
        finished   = 0;
        for (int c = 0; c < 300 && !finished; c++) begin
            start     = (c == 0);
            base_addr = v.base;
            length    = v.len;
            case (v.mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 2 == 0);
                default: out_ready = (c >= 10);
            endcase
            abort_now = (v.abort_after >= 0) && !aborted && (beats == v.abort_after);
            abort     = abort_now;
            if (abort_now) begin
                out_ready = 1'b0;
                aborted   = 1;
            end
            if (busy) saw_busy = 1;
            if (out_valid) saw_valid = 1;
            if (done) begin
                done_cnt++;
                done_cycle = c;
            end
            if (out_valid && out_ready) begin
                if (beats < 32) begin
                    got_data[beats]  = out_data;
                    got_last[beats]  = out_last;
                    got_cycle[beats] = c;
                end
                beats++;
            end
            step();
            abort = 1'b0;
            start = 1'b0;
            if (abort_now) begin
                check_output("abort_valid", 32'(out_valid), 32'd0);
                check_output("abort_busy", 32'(busy), 32'd0);
            end
            if (!busy) idle++;
            else idle = 0;
            if (idle >= 4) finished = 1;
        end
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        if (!finished) begin
            total++;
            bad++;
            $display("[TB] FAIL burst_timeout: got=busy expected=idle within 300 cycles");
        end
    endtask

    task automatic check_vector(input vec_t v);
        logic [12:0] e;
        check_output("beats", 32'(beats), 32'(v.exp_beats));
        for (int i = 0; i < beats && i < 32; i++) begin
            e = v.exp_first + 13'(i);
            check_output("beat_data", 32'(got_data[i]), 32'(e));
            check_output("beat_last", 32'(got_last[i]), 32'(v.exp_last && (i == v.exp_beats - 1)));
            if (v.mode == 0) check_output("beat_cycle", 32'(got_cycle[i]), 32'(3 + i));
        end
        check_output("done_count", 32'(done_cnt), 32'(v.exp_done));
        if (v.exp_done > 0 && done_cnt > 0) begin
            check_output("done_cycle", 32'(done_cycle),
                         32'((beats > 0 && beats <= 32) ? got_cycle[beats-1] + 1 : 1));
        end
        check_output("saw_busy", 32'(saw_busy), 32'(v.exp_busy));
        check_output("saw_valid", 32'(saw_valid), 32'(v.exp_beats > 0));
        check_output("raddr_end", 32'(ram_raddr), 32'(v.exp_raddr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_raddr"}, 32'(ram_raddr), 32'd0);
        check_output({tag, "_data"}, 32'(out_data), 32'd0);
        check_output({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_output({tag, "_last"}, 32'(out_last), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        n_rst     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b0;

        //          base      len    mode abort beats first    last done busy raddr_end
        vecs[0] = '{16'h0010, 16'd4,  0,   -1,   4,   13'h0010, 1'b1, 1, 1'b1, 16'h0014};
        vecs[1] = '{16'hFFFE, 16'd4,  0,   -1,   4,   13'h1FFE, 1'b1, 1, 1'b1, 16'h0002};
        vecs[2] = '{16'h0200, 16'd8,  1,   -1,   8,   13'h0200, 1'b1, 1, 1'b1, 16'h0208};
        vecs[3] = '{16'h0040, 16'd0,  0,   -1,   0,   13'h0000, 1'b0, 1, 1'b0, 16'h0040};
        vecs[4] = '{16'h0020, 16'd16, 0,    5,   5,   13'h0020, 1'b0, 0, 1'b1, 16'h0027};
        vecs[5] = '{16'h0100, 16'd2,  0,   -1,   2,   13'h0100, 1'b1, 1, 1'b1, 16'h0102};
        vecs[6] = '{16'h1FFF, 16'd1,  0,   -1,   1,   13'h1FFF, 1'b1, 1, 1'b1, 16'h2000};
        vecs[7] = '{16'h0300, 16'd3,  2,   -1,   3,   13'h0300, 1'b1, 1, 1'b1, 16'h0303};

        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        n_rst = 1'b1;
        step();

        for (int k = 0; k < 8; k++) begin
            apply_stimulus(vecs[k]);
            check_vector(vecs[k]);
        end

        // Reset pulsed in the middle of a long burst.
        start     = 1'b1;
        base_addr = 16'h0050;
        length    = 16'd16;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_output("midburst_busy", 32'(busy), 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        step();
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("postreset_done", 32'(done), 32'd0);
            check_output("postreset_valid", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        apply_stimulus(vecs[0]);
        check_vector(vecs[0]);

        // Abort and start together in IDLE: start must be ignored.
        start     = 1'b1;
        abort     = 1'b1;
        base_addr = 16'h0400;
        length    = 16'd3;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_output("abstart_busy", 32'(busy), 32'd0);
        check_output("abstart_raddr", 32'(ram_raddr), 32'h0014);
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("abstart_valid", 32'(out_valid), 32'd0);
            check_output("abstart_done", 32'(done), 32'd0);
        end
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
